apb_master_bridge: RTL and testbench

- APB requester (initiator) that drives the peripheral bus shared by the GPIO and UART APB slaves.
- Accepts single read/write commands on a simple valid/ready port from the host side.
- Decodes the address into a one-hot PSEL, runs the APB SETUP/ACCESS sequence and returns read data plus a status code.
- Provides a wait-state timeout so that a hung slave cannot stall the host.

---
 rtl/apb_master_bridge.sv | 166 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester: takes single host read/write commands, decodes one-hot PSEL for GPIO/UART,
// runs SETUP/ACCESS with a wait-state timeout, and returns a one-cycle response pulse.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_code,
  output logic [1:0]            PSEL,
  output logic                  PENABLE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic                  PWRITE,
  output logic [DATA_W-1:0]     PWDATA,
  output logic [2:0]            PPROT,
  input  logic [2*DATA_W-1:0]   PRDATA,
  input  logic [1:0]            PREADY,
  input  logic [1:0]            PSLVERR
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  localparam logic [1:0] RSP_OKAY    = 2'b00;
  localparam logic [1:0] RSP_SLVERR  = 2'b01;
  localparam logic [1:0] RSP_DECERR  = 2'b10;
  localparam logic [1:0] RSP_TIMEOUT = 2'b11;
  localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          sel_q, sel_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [1:0]          psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [2:0]          pprot_q, pprot_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_code_q, rsp_code_d;

  logic                accept, dec_err, pready_sel, pslverr_sel, timeout_hit;
  logic [1:0]          dec_field, dec_sel;
  logic [7:0]          cnt_inc;
  logic [DATA_W-1:0]   prdata_sel;

  // cmd_ready_q gates acceptance so nothing is taken on the reset-release edge
  assign accept    = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
  assign dec_field = cmd_addr[SEL_LSB+1:SEL_LSB];
  assign dec_err   = dec_field[1];
  assign dec_sel   = dec_field[0] ? 2'b10 : 2'b01;

  assign pready_sel  = |(PREADY & sel_q);
  assign pslverr_sel = |(PSLVERR & sel_q);
  assign prdata_sel  = sel_q[1] ? PRDATA[DATA_W +: DATA_W] : PRDATA[DATA_W-1:0];
  assign cnt_inc     = cnt_q + 8'd1;
  assign timeout_hit = (cnt_inc == TIMEOUT_C);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      cmd_ready_q <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_code_q  <= rsp_code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = dec_err ? S_RESP : S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (pready_sel || timeout_hit) state_d = S_RESP;
        if (!pready_sel) cnt_d = cnt_inc;
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the bus never sees a comb path from cmd_*
  always_comb begin
    sel_d       = sel_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pprot_d     = pprot_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_code_d  = rsp_code_q;
    if (accept) begin
      sel_d    = dec_err ? 2'b00 : dec_sel;
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      pwdata_d = cmd_wdata;
      pprot_d  = cmd_prot;
      if (dec_err) begin
        rsp_rdata_d = '0;
        rsp_code_d  = RSP_DECERR;
      end
    end
    if (state_q == S_ACCESS) begin
      if (pready_sel) begin
        rsp_rdata_d = (!pwrite_q && !pslverr_sel) ? prdata_sel : '0;
        rsp_code_d  = pslverr_sel ? RSP_SLVERR : RSP_OKAY;
      end else if (timeout_hit) begin
        rsp_rdata_d = '0;
        rsp_code_d  = RSP_TIMEOUT;
      end
    end
    cmd_ready_d = (state_d == S_IDLE);
    psel_d      = (state_d == S_SETUP || state_d == S_ACCESS) ? sel_d : 2'b00;
    penable_d   = (state_d == S_ACCESS);
    rsp_valid_d = (state_d == S_RESP);
  end

  assign cmd_ready = cmd_ready_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PPROT     = pprot_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_code  = rsp_code_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed vector table, randomized commands against a
// transaction-level model, and hand sequences for reset behaviour.
module tb_apb_master_bridge;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int SEL_LSB = 12;
  localparam int TIMEOUT = 16;

  logic                PCLK = 1'b0;
  logic                PRESETn = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_write = 1'b0;
  logic [ADDR_W-1:0]   cmd_addr = '0;
  logic [DATA_W-1:0]   cmd_wdata = '0;
  logic [2:0]          cmd_prot = '0;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [1:0]          rsp_code;
  logic [1:0]          PSEL;
  logic                PENABLE;
  logic [ADDR_W-1:0]   PADDR;
  logic                PWRITE;
  logic [DATA_W-1:0]   PWDATA;
  logic [2:0]          PPROT;
  logic [2*DATA_W-1:0] PRDATA = '0;
  logic [1:0]          PREADY = '0;
  logic [1:0]          PSLVERR = '0;

  apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_code(rsp_code),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial forever #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  prot;
    int          waits;   // wait states before the target slave raises PREADY
    bit          slverr;
    logic [31:0] rdata;
  } cmd_t;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] rdata;
    int          lat;     // cycles from accept edge to rsp_valid
    logic [1:0]  psel;
    int          acc;     // ACCESS cycles expected
  } exp_t;

  typedef struct {
    cmd_t c;
    exp_t e;
  } vec_t;

  // Transaction-level reference: outcome depends only on decode field, wait count and error flag
  function automatic exp_t model(input cmd_t c);
    exp_t e;
    int field;
    field = int'(c.addr[SEL_LSB +: 2]);
    if (field >= 2) begin
      e.code = 2'b10; e.rdata = '0; e.lat = 1; e.psel = 2'b00; e.acc = 0;
    end else begin
      e.psel = (field == 0) ? 2'b01 : 2'b10;
      if (c.waits + 1 > TIMEOUT) begin
        e.acc = TIMEOUT; e.code = 2'b11;
      end else begin
        e.acc = c.waits + 1; e.code = c.slverr ? 2'b01 : 2'b00;
      end
      e.lat   = 2 + e.acc;
      e.rdata = (e.code == 2'b00 && !c.wr) ? c.rdata : '0;
    end
    return e;
  endfunction

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] prot, input int waits, input bit slverr,
                              input logic [31:0] rdata, input logic [1:0] code,
                              input logic [31:0] erd, input int lat, input logic [1:0] psel,
                              input int acc);
    vec_t v;
    v.c.wr = wr; v.c.addr = addr; v.c.wdata = wdata; v.c.prot = prot;
    v.c.waits = waits; v.c.slverr = slverr; v.c.rdata = rdata;
    v.e.code = code; v.e.rdata = erd; v.e.lat = lat; v.e.psel = psel; v.e.acc = acc;
    return v;
  endfunction

  task automatic drive_slave_random();
    PREADY  = 2'($urandom);
    PSLVERR = 2'($urandom);
    PRDATA  = {$urandom, $urandom};
  endtask

  task automatic run_txn(input cmd_t c, input exp_t e, input string tag);
    int setup_n = 0;
    int acc_n   = 0;
    int bad     = 0;
    int lat     = -1;
    int tgt;
    logic [1:0]  act_code = 2'b00;
    logic [31:0] act_rdata = '0;
    tgt = int'(c.addr[SEL_LSB]);
    for (int i = 0; i < 8 && cmd_ready !== 1'b1; i++) @(negedge PCLK);
    chk({tag, " ready_before"}, 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = c.wr; cmd_addr = c.addr;
    cmd_wdata = c.wdata; cmd_prot = c.prot;
    drive_slave_random();
    for (int cy = 1; cy <= 64 && lat < 0; cy++) begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1) begin
        lat = cy; act_code = rsp_code; act_rdata = rsp_rdata;
        if (PSEL !== 2'b00 || PENABLE !== 1'b0) bad++;
        cmd_valid = 1'b0;
        drive_slave_random();
      end else begin
        if (cmd_ready !== 1'b0) bad++;
        if (PENABLE === 1'b1 && PSEL === 2'b00) bad++;
        if (PSEL !== 2'b00) begin
          if (PSEL !== e.psel) bad++;
          if (PADDR !== c.addr || PWRITE !== c.wr || PWDATA !== c.wdata || PPROT !== c.prot) bad++;
          if (PENABLE === 1'b1) acc_n++;
          else setup_n++;
        end
        drive_slave_random();
        if (PENABLE === 1'b1) begin
          PREADY[tgt] = (acc_n == c.waits + 1);
          if (PREADY[tgt]) begin
            PSLVERR[tgt] = c.slverr;
            PRDATA[tgt*DATA_W +: DATA_W] = c.rdata;
          end
        end
        // stray commands while busy must be ignored
        cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = $urandom;
        cmd_wdata = $urandom; cmd_prot = 3'($urandom);
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'(e.lat));
    chk({tag, " code"}, 64'(act_code), 64'(e.code));
    chk({tag, " rdata"}, 64'(act_rdata), 64'(e.rdata));
    chk({tag, " bus_protocol_errs"}, 64'(bad), 64'(0));
    chk({tag, " setup_cycles"}, 64'(setup_n), 64'(e.acc > 0 ? 1 : 0));
    chk({tag, " access_cycles"}, 64'(acc_n), 64'(e.acc));
    @(negedge PCLK);
    chk({tag, " rsp_pulse_end"}, 64'(rsp_valid), 64'(0));
    chk({tag, " ready_after"}, 64'(cmd_ready), 64'(1));
    chk({tag, " code_hold"}, 64'(rsp_code), 64'(e.code));
    chk({tag, " rdata_hold"}, 64'(rsp_rdata), 64'(e.rdata));
  endtask

  vec_t vecs[11];

  initial begin
    cmd_t c;
    vecs[0]  = mk(1'b1, 32'h0000_0004, 32'h0000_00A5, 3'd2, 0,  1'b0, 32'h0,         2'b00, 32'h0,         3,  2'b01, 1);
    vecs[1]  = mk(1'b0, 32'h0000_1000, 32'h0,         3'd0, 3,  1'b0, 32'h5A,        2'b00, 32'h5A,        6,  2'b10, 4);
    vecs[2]  = mk(1'b0, 32'h0000_0008, 32'h0,         3'd1, 1,  1'b1, 32'hDEAD,      2'b01, 32'h0,         4,  2'b01, 2);
    vecs[3]  = mk(1'b0, 32'h0000_2000, 32'h0,         3'd0, 0,  1'b0, 32'h77,        2'b10, 32'h0,         1,  2'b00, 0);
    vecs[4]  = mk(1'b1, 32'h0000_3004, 32'h99,        3'd7, 0,  1'b0, 32'h0,         2'b10, 32'h0,         1,  2'b00, 0);
    vecs[5]  = mk(1'b0, 32'h0000_1010, 32'h0,         3'd0, 20, 1'b0, 32'h33,        2'b11, 32'h0,         18, 2'b10, 16);
    vecs[6]  = mk(1'b0, 32'h0000_1020, 32'h0,         3'd5, 15, 1'b0, 32'h1234,      2'b00, 32'h1234,      18, 2'b10, 16);
    vecs[7]  = mk(1'b1, 32'h0000_000C, 32'h55AA,      3'd3, 2,  1'b1, 32'h0,         2'b01, 32'h0,         5,  2'b01, 3);
    vecs[8]  = mk(1'b1, 32'h0000_1FFC, 32'hFFFF_FFFF, 3'd4, 16, 1'b0, 32'h0,         2'b11, 32'h0,         18, 2'b10, 16);
    vecs[9]  = mk(1'b0, 32'hABCD_C010, 32'h0,         3'd6, 0,  1'b0, 32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 3,  2'b01, 1);
    vecs[10] = mk(1'b0, 32'h0000_1000, 32'h0,         3'd0, 15, 1'b1, 32'hBEEF,      2'b01, 32'h0,         18, 2'b10, 16);

    // reset values, and cmd_ready only after the first edge following release
    repeat (3) @(negedge PCLK);
    chk("rst cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst PSEL", 64'(PSEL), 64'(0));
    chk("rst PENABLE", 64'(PENABLE), 64'(0));
    chk("rst PADDR", 64'(PADDR), 64'(0));
    chk("rst PWRITE", 64'(PWRITE), 64'(0));
    chk("rst PWDATA", 64'(PWDATA), 64'(0));
    chk("rst PPROT", 64'(PPROT), 64'(0));
    chk("rst rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst rsp_code", 64'(rsp_code), 64'(0));
    PRESETn = 1'b1;
    #1 chk("release no_edge cmd_ready", 64'(cmd_ready), 64'(0));
    @(negedge PCLK);
    chk("release cmd_ready", 64'(cmd_ready), 64'(1));

    for (int i = 0; i < 11; i++) run_txn(vecs[i].c, vecs[i].e, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      c.wr = 1'($urandom); c.addr = $urandom; c.wdata = $urandom; c.prot = 3'($urandom);
      c.waits = $urandom_range(0, 20); c.slverr = 1'($urandom); c.rdata = $urandom;
      run_txn(c, model(c), $sformatf("rnd%0d", i));
    end

    // reset asserted in the middle of a stalled UART access
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_1000; cmd_wdata = '0; cmd_prot = '0;
    PREADY = '0; PSLVERR = '0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("rstmid PENABLE before", 64'(PENABLE), 64'(1));
    chk("rstmid PSEL before", 64'(PSEL), 64'(2));
    #1 PRESETn = 1'b0;
    #1;
    chk("rstmid PSEL async", 64'(PSEL), 64'(0));
    chk("rstmid PENABLE async", 64'(PENABLE), 64'(0));
    chk("rstmid cmd_ready async", 64'(cmd_ready), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk($sformatf("rstmid no_rsp%0d", i), 64'(rsp_valid), 64'(0));
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("rstmid cmd_ready after", 64'(cmd_ready), 64'(1));
    chk("rstmid rsp_valid after", 64'(rsp_valid), 64'(0));

    c.wr = 1'b0; c.addr = 32'h0000_0010; c.wdata = '0; c.prot = 3'd1;
    c.waits = 0; c.slverr = 1'b0; c.rdata = 32'h1357_9BDF;
    run_txn(c, model(c), "post_rst_gpio");
    // a full 15-wait-state access must still complete, so the counter was cleared by reset
    c.addr = 32'h0000_1004; c.waits = 15; c.rdata = 32'h2468_ACE0;
    run_txn(c, model(c), "post_rst_uart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
